// File: rtl/mult_div_unit.sv
// Signed multiply/divide unit holding the HI/LO pair.
// Radix-2 Booth multiply, restoring divide, one bit per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]    cnt;
    logic             last;
    logic             dz;

    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] acc;
    logic [WIDTH:0]   bo_hi;
    logic [WIDTH:0]   bo_m;
    logic [WIDTH:0]   bo_sum;
    logic [2*WIDTH:0] acc_nxt;

    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH:0]   d_sh;
    logic [WIDTH:0]   d_sub;
    logic             d_ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quot_nxt;
    logic [WIDTH-1:0] hi_div;
    logic [WIDTH-1:0] lo_div;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;

    assign last   = (cnt == CW'(ITER - 1));
    assign b_zero = (b == '0);
    assign a_mag  = a[WIDTH-1] ? -a : a;
    assign b_mag  = b[WIDTH-1] ? -b : b;

    assign busy     = (state == MULT) || (state == DIV);
    assign done     = (state == FIN);
    assign div_zero = (state == FIN) && dz;

    // Booth step: 33-bit add keeps the most negative multiplicand exact
    always_comb begin
        bo_hi = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        bo_m  = {mcand[WIDTH-1], mcand};
        unique case (1'b1)
            (acc[1:0] == 2'b01): bo_sum = bo_hi + bo_m;
            (acc[1:0] == 2'b10): bo_sum = bo_hi - bo_m;
            default:             bo_sum = bo_hi;
        endcase
        acc_nxt = {bo_sum, acc[WIDTH:1]};
    end

    // Restoring divide step plus sign fix-up of the final result
    always_comb begin
        d_sh     = {rem, quot[WIDTH-1]};
        d_sub    = d_sh - {1'b0, dvsr};
        d_ge     = ~d_sub[WIDTH];
        rem_nxt  = d_ge ? d_sub[WIDTH-1:0] : d_sh[WIDTH-1:0];
        quot_nxt = {quot[WIDTH-2:0], d_ge};
        lo_div   = neg_q ? -quot_nxt : quot_nxt;
        hi_div   = neg_r ? -rem_nxt : rem_nxt;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (!op)        state_nxt = MULT;
                    else if (b_zero) state_nxt = FIN;
                    else            state_nxt = DIV;
                end
            end
            MULT:    if (last) state_nxt = FIN;
            DIV:     if (last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and HI/LO write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            dz    <= 1'b0;
            mcand <= '0;
            acc   <= '0;
            dvsr  <= '0;
            rem   <= '0;
            quot  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        dz <= op && b_zero;
                        if (!op) begin
                            mcand <= a;
                            acc   <= {{WIDTH{1'b0}}, b, 1'b0};
                        end else if (!b_zero) begin
                            dvsr  <= b_mag;
                            quot  <= a_mag;
                            rem   <= '0;
                            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r <= a[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi <= acc_nxt[2*WIDTH:WIDTH+1];
                        lo <= acc_nxt[WIDTH:1];
                    end
                end
                DIV: begin
                    rem  <= rem_nxt;
                    quot <= quot_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        hi <= hi_div;
                        lo <= lo_div;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request; returns in cycle T+1 with inputs scrambled
    task automatic start_op(input logic o,
                            input logic [31:0] x,
                            input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        op    = ~o;
        a     = 32'h1234_5678;
        b     = 32'h0000_0000;
    endtask

    // Wait for done; n is the cycle index relative to T
    task automatic wait_done(input int from,
                             output int n,
                             output logic busy_ok);
        n       = from;
        busy_ok = 1'b1;
        while (!done && n < from + 45) begin
            if (!busy) busy_ok = 1'b0;
            step();
            n++;
        end
    endtask

    task automatic run(input string tag,
                       input logic o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input int lat,
                       input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo,
                       input logic exp_dz);
        int   n;
        logic bok;
        start_op(o, x, y);
        wait_done(1, n, bok);
        check({tag, " lat"}, n, lat);
        check({tag, " busy"}, {31'd0, bok}, 32'd1);
        check({tag, " fin_busy"}, {31'd0, busy}, 32'd0);
        check({tag, " dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        step();
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " dz_pulse"}, {31'd0, div_zero}, 32'd0);
    endtask

    initial begin
        int   n;
        logic bok;
        logic seen;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst dz", {31'd0, div_zero}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        reset = 1'b0;
        step();

        run("m7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 33,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run("mmin2", 1'b0, 32'h8000_0000, 32'h8000_0000, 33,
            32'h4000_0000, 32'h0000_0000, 1'b0);
        run("m-1x-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
            32'h0000_0000, 32'h0000_0001, 1'b0);
        run("d-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("dovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33,
            32'h0000_0000, 32'h8000_0000, 1'b0);
        run("m3x5", 1'b0, 32'd3, 32'd5, 33,
            32'd0, 32'd15, 1'b0);
        run("d10/0", 1'b1, 32'd10, 32'd0, 1,
            32'd0, 32'd15, 1'b1);
        check("dz idle busy", {31'd0, busy}, 32'd0);

        // Starts during busy and during FIN must be ignored
        start_op(1'b0, 32'd6, 32'd7);
        repeat (4) step();
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd100;
        b     = 32'd3;
        step();
        start = 1'b0;
        wait_done(6, n, bok);
        check("ign lat", n, 33);
        check("ign busy", {31'd0, bok}, 32'd1);
        check("ign hi", hi, 32'd0);
        check("ign lo", lo, 32'd42);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd100;
        b     = 32'd3;
        step();
        start = 1'b0;
        check("fin start busy", {31'd0, busy}, 32'd0);
        check("fin start done", {31'd0, done}, 32'd0);
        run("m2x3@34", 1'b0, 32'd2, 32'd3, 33,
            32'd0, 32'd6, 1'b0);

        // Reset in the middle of a divide
        start_op(1'b1, 32'd100, 32'd3);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst done", {31'd0, done}, 32'd0);
        check("mid rst hi", hi, 32'd0);
        check("mid rst lo", lo, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen = 1'b1;
            step();
        end
        check("mid rst quiet", {31'd0, seen}, 32'd0);
        run("d100/3", 1'b1, 32'd100, 32'd3, 33,
            32'd1, 32'd33, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
